// File: rtl/snake_pkg.sv
// Shared types and constants for the snake movement controller.
// Direction codes match the movement datapath's 3-bit direction input.
package snake_pkg;

    localparam int IDX_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SWEEP,
        OVER
    } seqState_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'b000,
        DIR_UP    = 3'b001,
        DIR_DOWN  = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_RIGHT = 3'b100
    } dir_t;

    // True when b would make the snake turn straight back onto itself while moving in a.
    function automatic logic isReverse(input dir_t a, input dir_t b);
        logic result;
        result = 1'b0;
        case (a)
            DIR_UP:    result = (b == DIR_DOWN);
            DIR_DOWN:  result = (b == DIR_UP);
            DIR_LEFT:  result = (b == DIR_RIGHT);
            DIR_RIGHT: result = (b == DIR_LEFT);
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Button decode and pending-direction register: accepts a single pressed button
// unless it would reverse the direction the snake is currently moving in.
module snake_dir_latch
    import snake_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    input  logic enable,
    input  dir_t currentDir,
    output dir_t pendingDir,
    output logic pressAccepted
);

    dir_t pressDir;

    // Chords and idle buttons decode to no press at all.
    always_comb begin
        pressDir = DIR_NONE;
        case ({up, down, left, right})
            4'b1000: pressDir = DIR_UP;
            4'b0100: pressDir = DIR_DOWN;
            4'b0010: pressDir = DIR_LEFT;
            4'b0001: pressDir = DIR_RIGHT;
            default: pressDir = DIR_NONE;
        endcase
    end

    assign pressAccepted = enable && (pressDir != DIR_NONE) && !isReverse(currentDir, pressDir);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pendingDir <= DIR_NONE;
        end else if (pressAccepted) begin
            pendingDir <= pressDir;
        end
    end

endmodule

// File: rtl/snake_tick_sequencer.sv
// Game-tick controller: divides the clock into ticks, sweeps the segment index
// over the snake once per tick, and tracks length, growth and game-over.
module snake_tick_sequencer #(
    parameter int TICK_DIV = 2500000,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 64,
    parameter int IDX_W    = snake_pkg::IDX_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             Up,
    input  logic             Down,
    input  logic             Left,
    input  logic             Right,
    input  logic             grow,
    input  logic             collide,
    output logic [IDX_W-1:0] bitNum,
    output logic             segValid,
    output logic             dirUp,
    output logic             dirDown,
    output logic             dirLeft,
    output logic             dirRight,
    output logic             frameDone,
    output logic             gameOver,
    output logic [IDX_W-1:0] length
);
    import snake_pkg::*;

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] LEN_INIT  = IDX_W'(INIT_LEN);
    localparam logic [IDX_W-1:0] LEN_MAX   = IDX_W'(MAX_LEN);

    seqState_t        state;
    seqState_t        nextState;
    logic [CNT_W-1:0] tickCnt;
    logic [CNT_W-1:0] nextTickCnt;
    logic [IDX_W-1:0] nextBitNum;
    logic [IDX_W-1:0] nextLength;
    logic             nextSegValid;
    logic             nextFrameDone;
    logic             nextGameOver;
    logic             growPending;
    logic             nextGrowPending;
    logic             loadDir;
    logic             captureEn;
    logic             pressAccepted;
    dir_t             pendingDir;
    dir_t             curDir;

    assign captureEn = (state != OVER);

    snake_dir_latch uDirLatch (
        .clock         (clock),
        .resetn        (resetn),
        .up            (Up),
        .down          (Down),
        .left          (Left),
        .right         (Right),
        .enable        (captureEn),
        .currentDir    (curDir),
        .pendingDir    (pendingDir),
        .pressAccepted (pressAccepted)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A collision on the final index wins over completing the frame.
    always_comb begin
        nextState     = state;
        nextTickCnt   = tickCnt;
        nextBitNum    = bitNum;
        nextSegValid  = segValid;
        nextFrameDone = 1'b0;
        nextGameOver  = gameOver;
        loadDir       = 1'b0;
        unique case (state)
            IDLE: begin
                nextTickCnt = '0;
                if (pressAccepted) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (tickCnt == TICK_LAST) begin
                    nextTickCnt  = '0;
                    nextBitNum   = '0;
                    nextSegValid = 1'b1;
                    loadDir      = 1'b1;
                    nextState    = SWEEP;
                end else begin
                    nextTickCnt = tickCnt + 1'b1;
                end
            end
            SWEEP: begin
                if (collide) begin
                    nextState    = OVER;
                    nextSegValid = 1'b0;
                    nextBitNum   = '0;
                    nextGameOver = 1'b1;
                end else if (bitNum == length - 1'b1) begin
                    nextState     = WAIT;
                    nextSegValid  = 1'b0;
                    nextBitNum    = '0;
                    nextFrameDone = 1'b1;
                end else begin
                    nextBitNum = bitNum + 1'b1;
                end
            end
            OVER: begin
                nextSegValid = 1'b0;
                nextGameOver = 1'b1;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Length only moves in the frameDone cycle, which sits outside any sweep.
    always_comb begin
        nextLength      = length;
        nextGrowPending = growPending;
        if (state != OVER) begin
            if (frameDone && (growPending || grow)) begin
                nextLength      = (length >= LEN_MAX) ? length : length + 1'b1;
                nextGrowPending = 1'b0;
            end else if (grow) begin
                nextGrowPending = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tickCnt     <= '0;
            bitNum      <= '0;
            segValid    <= 1'b0;
            frameDone   <= 1'b0;
            gameOver    <= 1'b0;
            length      <= LEN_INIT;
            growPending <= 1'b0;
            curDir      <= DIR_NONE;
        end else begin
            tickCnt     <= nextTickCnt;
            bitNum      <= nextBitNum;
            segValid    <= nextSegValid;
            frameDone   <= nextFrameDone;
            gameOver    <= nextGameOver;
            length      <= nextLength;
            growPending <= nextGrowPending;
            if (loadDir) begin
                curDir <= pendingDir;
            end
        end
    end

    assign dirUp    = (curDir == DIR_UP);
    assign dirDown  = (curDir == DIR_DOWN);
    assign dirLeft  = (curDir == DIR_LEFT);
    assign dirRight = (curDir == DIR_RIGHT);

endmodule

// File: tb/tb_snake_tick_sequencer.sv
// Bench for snake_tick_sequencer: directed vector table, corner-case sequences
// and randomized play against a frame-phase reference model.
module tb_snake_tick_sequencer;

    localparam int TICK_DIV = 4;
    localparam int INIT_LEN = 3;
    localparam int MAX_LEN  = 4;
    localparam int IDX_W    = 20;

    logic             clock = 1'b0;
    logic             resetn;
    logic             Up, Down, Left, Right, grow, collide;
    logic [IDX_W-1:0] bitNum, length;
    logic             segValid, dirUp, dirDown, dirLeft, dirRight, frameDone, gameOver;

    int testsRun    = 0;
    int testsFailed = 0;

    snake_tick_sequencer #(
        .TICK_DIV (TICK_DIV),
        .INIT_LEN (INIT_LEN),
        .MAX_LEN  (MAX_LEN),
        .IDX_W    (IDX_W)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .Up        (Up),
        .Down      (Down),
        .Left      (Left),
        .Right     (Right),
        .grow      (grow),
        .collide   (collide),
        .bitNum    (bitNum),
        .segValid  (segValid),
        .dirUp     (dirUp),
        .dirDown   (dirDown),
        .dirLeft   (dirLeft),
        .dirRight  (dirRight),
        .frameDone (frameDone),
        .gameOver  (gameOver),
        .length    (length)
    );

    always #5 clock = ~clock;

    // Reference model: one phase counter per frame (0..TICK_DIV-1 waiting, then one cycle per segment).
    bit mStarted, mOver, mGrowReq, mFd;
    int mPhase, mLen, mPend, mCur;

    task automatic modelReset();
        mStarted = 0; mOver = 0; mGrowReq = 0; mFd = 0;
        mPhase = 0; mLen = INIT_LEN; mPend = 0; mCur = 0;
    endtask

    function automatic int decodeBtn(input logic [3:0] b);
        case (b)
            4'b1000: return 1;
            4'b0100: return 2;
            4'b0010: return 3;
            4'b0001: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit opposite(input int a, input int b);
        return (a == 1 && b == 2) || (a == 2 && b == 1) || (a == 3 && b == 4) || (a == 4 && b == 3);
    endfunction

    function automatic logic [3:0] dirBits(input int d);
        case (d)
            1: return 4'b1000;
            2: return 4'b0100;
            3: return 4'b0010;
            4: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit modelSeg();
        return mStarted && !mOver && mPhase >= TICK_DIV;
    endfunction

    function automatic int modelBit();
        return modelSeg() ? mPhase - TICK_DIV : 0;
    endfunction

    task automatic modelStep(input logic [3:0] b, input logic g, input logic c);
        int press;
        int newCur;
        int newPend;
        bit fdNow;
        bit sweeping;
        press    = decodeBtn(b);
        fdNow    = mFd;
        sweeping = modelSeg();
        newCur   = mCur;
        newPend  = mPend;
        mFd      = 0;
        if (!mOver) begin
            if (press != 0 && !opposite(mCur, press)) newPend = press;
            if (!mStarted) begin
                if (press != 0) begin
                    mStarted = 1;
                    mPhase   = 0;
                end
            end else if (sweeping && c) begin
                mOver = 1;
            end else begin
                mPhase++;
                if (mPhase == TICK_DIV) newCur = mPend;
                if (mPhase == TICK_DIV + mLen) begin
                    mPhase = 0;
                    mFd    = 1;
                end
            end
            if (fdNow && (mGrowReq || g)) begin
                mLen     = (mLen + 1 > MAX_LEN) ? MAX_LEN : mLen + 1;
                mGrowReq = 0;
            end else if (g) begin
                mGrowReq = 1;
            end
            mCur  = newCur;
            mPend = newPend;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic g, input logic c);
        {Up, Down, Left, Right} = b;
        grow    = g;
        collide = c;
        @(posedge clock);
        modelStep(b, g, c);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input int eBit, input logic eSeg, input logic [3:0] eDir,
                               input logic eFd, input logic eGo, input int eLen);
        testsRun++;
        if (bitNum !== IDX_W'(eBit) || segValid !== eSeg || {dirUp, dirDown, dirLeft, dirRight} !== eDir ||
            frameDone !== eFd || gameOver !== eGo || length !== IDX_W'(eLen)) begin
            testsFailed++;
            $display("[TB] FAIL %s: got bitNum=%0d segValid=%b dir=%b frameDone=%b gameOver=%b length=%0d, want bitNum=%0d segValid=%b dir=%b frameDone=%b gameOver=%b length=%0d",
                     name, bitNum, segValid, {dirUp, dirDown, dirLeft, dirRight}, frameDone, gameOver, length,
                     eBit, eSeg, eDir, eFd, eGo, eLen);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, modelBit(), modelSeg(), dirBits(mCur), mFd, mOver, mLen);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        {Up, Down, Left, Right} = 4'b0000;
        grow    = 1'b0;
        collide = 1'b0;
        repeat (2) @(negedge clock);
        modelReset();
        resetn = 1'b1;
    endtask

    task automatic runUntilBit(input int target, input string name);
        int k = 0;
        while (!(modelSeg() && modelBit() == target) && k < 40) begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
            checkModel(name);
            k++;
        end
        if (!(modelSeg() && modelBit() == target)) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: sweep index %0d never reached", name, target);
        end
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       g;
        logic       c;
        int         eBit;
        logic       eSeg;
        logic [3:0] eDir;
        logic       eFd;
        logic       eGo;
        int         eLen;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] btn, input logic g, input logic c, input int eBit, input logic eSeg,
                                input logic [3:0] eDir, input logic eFd, input logic eGo, input int eLen);
        vec_t v;
        v.btn = btn; v.g = g; v.c = c; v.eBit = eBit; v.eSeg = eSeg;
        v.eDir = eDir; v.eFd = eFd; v.eGo = eGo; v.eLen = eLen;
        return v;
    endfunction

    initial begin
        int overCycles;
        logic [3:0] rb;

        // Inputs applied during each cycle, outputs expected after its rising edge.
        vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 2, 1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 1, 0, 3));
        vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b1010, 0, 0, 0, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b1000, 0, 0, 1, 1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 2, 1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 1, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 4'b1000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 1, 4'b1000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 2, 1, 4'b1000, 0, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1000, 1, 0, 3));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 1, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 2, 1, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 3, 1, 4'b1000, 0, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1000, 1, 0, 4));

        doReset();
        checkOutput("reset", 0, 1'b0, 4'b0000, 1'b0, 1'b0, INIT_LEN);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].btn, vecs[i].g, vecs[i].c);
            checkOutput($sformatf("vec%0d", i), vecs[i].eBit, vecs[i].eSeg, vecs[i].eDir,
                        vecs[i].eFd, vecs[i].eGo, vecs[i].eLen);
            checkModel($sformatf("vecModel%0d", i));
        end

        // Grow coincident with frameDone at MAX_LEN saturates.
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("growSaturate", 0, 1'b0, 4'b1000, 1'b0, 1'b0, MAX_LEN);
        for (int k = 0; k < TICK_DIV + MAX_LEN + 1; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
            checkModel("afterSaturate");
        end

        // Three grow pulses in one frame add a single segment.
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            checkModel("growPulses");
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
            checkModel("growFrame");
        end
        checkOutput("growOnce", 0, 1'b0, 4'b0001, 1'b0, 1'b0, INIT_LEN + 1);

        // Collision mid-sweep freezes the game; buttons and grow are ignored afterwards.
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        runUntilBit(1, "toCollideMid");
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("collideMid", 0, 1'b0, 4'b0001, 1'b0, 1'b1, INIT_LEN);
        for (int k = 0; k < 2 * (TICK_DIV + INIT_LEN); k++) begin
            applyStimulus((k % 2 == 0) ? 4'b1000 : 4'b0100, 1'b1, 1'b0);
            checkOutput("overFrozen", 0, 1'b0, 4'b0001, 1'b0, 1'b1, INIT_LEN);
        end

        // Collide in WAIT is ignored; collide on the last index beats frameDone.
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("collideWait", 0, 1'b0, 4'b0000, 1'b0, 1'b0, INIT_LEN);
        runUntilBit(INIT_LEN - 1, "toCollideLast");
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("collideLast", 0, 1'b0, 4'b0001, 1'b0, 1'b1, INIT_LEN);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("collideLastHold", 0, 1'b0, 4'b0001, 1'b0, 1'b1, INIT_LEN);

        // Asynchronous reset in the middle of a sweep.
        doReset();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        runUntilBit(2, "toAsyncReset");
        #2 resetn = 1'b0;
        #1 checkOutput("asyncReset", 0, 1'b0, 4'b0000, 1'b0, 1'b0, INIT_LEN);
        @(negedge clock);
        modelReset();
        resetn = 1'b1;
        for (int k = 0; k < TICK_DIV + 2; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
            checkModel("idleAfterReset");
        end
        checkOutput("stillIdle", 0, 1'b0, 4'b0000, 1'b0, 1'b0, INIT_LEN);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        runUntilBit(0, "restartSweep");
        checkOutput("restartDir", 0, 1'b1, 4'b0100, 1'b0, 1'b0, INIT_LEN);

        // Randomized play against the reference model.
        doReset();
        overCycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (mOver) overCycles++;
            if (overCycles > 12) begin
                doReset();
                checkOutput("randReset", 0, 1'b0, 4'b0000, 1'b0, 1'b0, INIT_LEN);
                overCycles = 0;
            end
            rb = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            applyStimulus(rb, ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
            checkModel("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
